// File: rtl/mac_pkg.sv
// Shared helpers for the MAC / dot-product datapath blocks.
// Width derivation and saturation limits, reused by conv/pooling blocks.
package mac_pkg;

   // Ceiling log2, with clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v << 1) begin
         r++;
      end
      return r;
   endfunction

   // Full-precision product width.
   function automatic int prod_w(input int aw, input int bw);
      return aw + bw;
   endfunction

   // Width of a reduced sum of 'lanes' products; cannot overflow.
   function automatic int sum_w(input int aw, input int bw,
                                input int lanes);
      return aw + bw + clog2(lanes);
   endfunction

   // Largest signed value representable in w bits.
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest signed value representable in w bits.
   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Combinational balanced adder tree reducing LANES signed products.
// Ports: prod_i packed products (lane 0 in LSBs), sum_o signed SUM_W sum.
module dot_adder_tree
   import mac_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int PROD_W = 16,
   parameter int SUM_W  = PROD_W + clog2(LANES)
) (
   input  logic [LANES*PROD_W-1:0] prod_i,
   output logic [SUM_W-1:0]        sum_o
);

   // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, root at 0.
   logic signed [SUM_W-1:0] node [2*LANES-1];

   for (genvar i = 0; i < LANES; i++) begin : g_leaf
      assign node[LANES-1+i] =
         SUM_W'($signed(prod_i[i*PROD_W +: PROD_W]));
   end

   for (genvar i = 0; i < LANES - 1; i++) begin : g_node
      assign node[i] = node[2*i+1] + node[2*i+2];
   end

   assign sum_o = node[0];

endmodule

// File: rtl/dot_product_accum.sv
// LANES-wide signed dot product, accumulated over a multi-beat packet.
// Ports: clk/rst, in_* beat handshake + a_vec/b_vec/bias, out_* result.
module dot_product_accum
   import mac_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int A_WIDTH     = 8,
   parameter int B_WIDTH     = 8,
   parameter int ACCUM_WIDTH = 24,
   parameter int SATURATE    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic [LANES*A_WIDTH-1:0] a_vec,
   input  logic [LANES*B_WIDTH-1:0] b_vec,
   input  logic [ACCUM_WIDTH-1:0]   bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACCUM_WIDTH-1:0]   out_data,
   output logic                     out_overflow
);

   localparam int PROD_W = prod_w(A_WIDTH, B_WIDTH);
   localparam int SUM_W  = sum_w(A_WIDTH, B_WIDTH, LANES);
   localparam int EXT_W  = ACCUM_WIDTH + 1;

   localparam logic [ACCUM_WIDTH-1:0] MAX_C =
      ACCUM_WIDTH'(sat_max(ACCUM_WIDTH));
   localparam logic [ACCUM_WIDTH-1:0] MIN_C =
      ACCUM_WIDTH'(sat_min(ACCUM_WIDTH));

   // Whole pipeline advances together; stalls only on a held result.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- S1: per-lane multiply ----------------
   logic [LANES*PROD_W-1:0] prod_d;
   logic [LANES*PROD_W-1:0] s1_prod_q;
   logic                    s1_v_q;
   logic                    s1_first_q;
   logic                    s1_last_q;
   logic [ACCUM_WIDTH-1:0]  s1_bias_q;

   always_comb begin
      logic signed [A_WIDTH-1:0] av;
      logic signed [B_WIDTH-1:0] bv;
      logic signed [PROD_W-1:0]  p;
      prod_d = '0;
      for (int i = 0; i < LANES; i++) begin
         av = a_vec[i*A_WIDTH +: A_WIDTH];
         bv = b_vec[i*B_WIDTH +: B_WIDTH];
         p  = av * bv;
         prod_d[i*PROD_W +: PROD_W] = p;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_bias_q  <= '0;
         s1_prod_q  <= '0;
      end else if (adv) begin
         s1_v_q     <= in_valid;
         s1_first_q <= in_first;
         s1_last_q  <= in_last;
         s1_bias_q  <= bias;
         s1_prod_q  <= prod_d;
      end
   end

   // ---------------- S2: lane reduction ----------------
   logic [SUM_W-1:0]        sum_d;
   logic signed [SUM_W-1:0] s2_sum_q;
   logic                    s2_v_q;
   logic                    s2_first_q;
   logic                    s2_last_q;
   logic [ACCUM_WIDTH-1:0]  s2_bias_q;

   dot_adder_tree #(
      .LANES  (LANES),
      .PROD_W (PROD_W),
      .SUM_W  (SUM_W)
   ) u_tree (
      .prod_i (s1_prod_q),
      .sum_o  (sum_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v_q     <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_bias_q  <= '0;
         s2_sum_q   <= '0;
      end else if (adv) begin
         s2_v_q     <= s1_v_q;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         s2_bias_q  <= s1_bias_q;
         s2_sum_q   <= sum_d;
      end
   end

   // ---------------- S3: accumulate ----------------
   logic signed [ACCUM_WIDTH-1:0] acc_q;
   logic [ACCUM_WIDTH-1:0]        acc_d;
   logic                          ovf_q;
   logic                          ovf_d;
   logic                          open_q;
   logic                          open_d;
   logic                          s3_v_q;
   logic                          s3_last_q;

   logic                    eff_first;
   logic signed [EXT_W-1:0] sum_x;
   logic signed [EXT_W-1:0] base_x;
   logic signed [EXT_W-1:0] raw;
   logic                    beat_ovf;

   // A stray non-first beat with no open packet restarts with bias.
   assign eff_first = s2_first_q || !open_q;

   always_comb begin
      sum_x    = EXT_W'(s2_sum_q);
      base_x   = eff_first ? EXT_W'($signed(s2_bias_q))
                           : EXT_W'(acc_q);
      raw      = base_x + sum_x;
      // One guard bit: overflow iff the top two bits disagree.
      beat_ovf = raw[EXT_W-1] ^ raw[EXT_W-2];
   end

   always_comb begin
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      open_d = open_q;
      if (s2_v_q) begin
         open_d = !s2_last_q;
         ovf_d  = (eff_first ? 1'b0 : ovf_q) | beat_ovf;
         if (beat_ovf && (SATURATE != 0)) begin
            acc_d = raw[EXT_W-1] ? MIN_C : MAX_C;
         end else begin
            acc_d = raw[ACCUM_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         open_q    <= 1'b0;
         s3_v_q    <= 1'b0;
         s3_last_q <= 1'b0;
      end else if (adv) begin
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         open_q    <= open_d;
         s3_v_q    <= s2_v_q;
         s3_last_q <= s2_last_q;
      end
   end

   // ---------------- Output register ----------------
   logic                   out_valid_q;
   logic [ACCUM_WIDTH-1:0] out_data_q;
   logic                   out_ovf_q;
   logic                   res_rdy;

   assign res_rdy = s3_v_q && s3_last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= res_rdy;
         if (res_rdy) begin
            out_data_q <= acc_q;
            out_ovf_q  <= ovf_q;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_dot_product_accum.sv
// Directed bench for dot_product_accum: one saturating, one wrapping DUT.
// Both see identical stimulus; each result is checked against constants.
module tb_dot_product_accum;

   localparam int LANES = 4;
   localparam int AW    = 8;
   localparam int BW    = 8;
   localparam int ACW   = 24;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_first = 1'b0;
   logic            in_last = 1'b0;
   logic            out_ready = 1'b1;
   logic [31:0]     a_vec = '0;
   logic [31:0]     b_vec = '0;
   logic [ACW-1:0]  bias = '0;

   logic            in_ready_s, in_ready_w;
   logic            out_valid_s, out_valid_w;
   logic            ovf_s, ovf_w;
   logic [ACW-1:0]  data_s, data_w;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int n_push = 0;
   int n_res_s = 0;
   int n_res_w = 0;
   logic [24:0] exp_s[$];
   logic [24:0] exp_w[$];
   int res_cyc[$];

   localparam logic [31:0] A1  = 32'h04030201;
   localparam logic [31:0] B1  = 32'h08070605;
   localparam logic [31:0] AM1 = 32'hFFFFFFFF;
   localparam logic [31:0] B2  = 32'h02020202;
   localparam logic [31:0] AN  = 32'h80808080;

   dot_product_accum #(
      .LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW),
      .ACCUM_WIDTH(ACW), .SATURATE(1)
   ) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .in_first(in_first), .in_last(in_last),
      .a_vec(a_vec), .b_vec(b_vec), .bias(bias),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(data_s), .out_overflow(ovf_s)
   );

   dot_product_accum #(
      .LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW),
      .ACCUM_WIDTH(ACW), .SATURATE(0)
   ) dut_w (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_w),
      .in_first(in_first), .in_last(in_last),
      .a_vec(a_vec), .b_vec(b_vec), .bias(bias),
      .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(data_w), .out_overflow(ovf_w)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [ACW-1:0] ds, input logic os,
                       input logic [ACW-1:0] dw, input logic ow);
      exp_s.push_back({os, ds});
      exp_w.push_back({ow, dw});
      n_push++;
   endtask

   // Called at a falling edge; returns at the falling edge after accept.
   task automatic send(input logic f, input logic l,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [ACW-1:0] bs);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      a_vec    = a;
      b_vec    = b;
      bias     = bs;
      #1;
      while (!(in_ready_s && in_ready_w) && g < 100) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_s.size() != 0 || exp_w.size() != 0) && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (g >= 500) chk("drain_timeout", 64'd0, 64'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [24:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && out_valid_s && out_ready) begin
            n_res_s++;
            if (exp_s.size() == 0) begin
               chk("extra_result_s", 64'(data_s), 64'hDEAD);
            end else begin
               e = exp_s.pop_front();
               chk("data_s", 64'(data_s), 64'(e[23:0]));
               chk("ovf_s", 64'(ovf_s), 64'(e[24]));
               res_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      logic [24:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && out_valid_w && out_ready) begin
            n_res_w++;
            if (exp_w.size() == 0) begin
               chk("extra_result_w", 64'(data_w), 64'hDEAD);
            end else begin
               e = exp_w.pop_front();
               chk("data_w", 64'(data_w), 64'(e[23:0]));
               chk("ovf_w", 64'(ovf_w), 64'(e[24]));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid_s), 64'd0);
      chk("rst_out_data", 64'(data_s), 64'd0);
      chk("rst_out_ovf", 64'(ovf_s), 64'd0);
      chk("rst_in_ready", 64'(in_ready_s), 64'd1);
      rst = 1'b0;
      @(negedge clk);

      // Single beat: 70 + 10, latency 3 edges after accept
      push(24'd80, 1'b0, 24'd80, 1'b0);
      send(1'b1, 1'b1, A1, B1, 24'd10);
      idle();
      chk("lat_t0", 64'(out_valid_s), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_t2", 64'(out_valid_s), 64'd0);
      @(negedge clk);
      chk("lat_t3", 64'(out_valid_s), 64'd1);
      drain();

      // Two-beat packet: 80 - 8; bias of the second beat is ignored
      push(24'd72, 1'b0, 24'd72, 1'b0);
      send(1'b1, 1'b0, A1, B1, 24'd10);
      send(1'b0, 1'b1, AM1, B2, 24'd999);
      idle();
      drain();

      // Same packet with bubbles between the beats
      push(24'd72, 1'b0, 24'd72, 1'b0);
      send(1'b1, 1'b0, A1, B1, 24'd10);
      idle();
      repeat (3) @(negedge clk);
      send(1'b0, 1'b1, AM1, B2, 24'd5);
      idle();
      drain();

      // Back-to-back two-beat packets
      push(24'd72, 1'b0, 24'd72, 1'b0);
      push(24'd72, 1'b0, 24'd72, 1'b0);
      send(1'b1, 1'b0, A1, B1, 24'd10);
      send(1'b0, 1'b1, AM1, B2, 24'd0);
      send(1'b1, 1'b0, A1, B1, 24'd10);
      send(1'b0, 1'b1, AM1, B2, 24'd0);
      idle();
      drain();

      // Four single-beat packets at full rate: one result per cycle
      push(24'd80, 1'b0, 24'd80, 1'b0);
      push(24'd90, 1'b0, 24'd90, 1'b0);
      push(24'd100, 1'b0, 24'd100, 1'b0);
      push(24'd110, 1'b0, 24'd110, 1'b0);
      send(1'b1, 1'b1, A1, B1, 24'd10);
      send(1'b1, 1'b1, A1, B1, 24'd20);
      send(1'b1, 1'b1, A1, B1, 24'd30);
      send(1'b1, 1'b1, A1, B1, 24'd40);
      idle();
      drain();
      n = res_cyc.size();
      if (n >= 4) chk("burst_span", 64'(res_cyc[n-1] - res_cyc[n-4]), 64'd3);
      else chk("burst_count", 64'(n), 64'd4);

      // First beat while a packet is open restarts it
      push(24'd80, 1'b0, 24'd80, 1'b0);
      send(1'b1, 1'b0, A1, B1, 24'd1000);
      send(1'b1, 1'b1, A1, B1, 24'd10);
      idle();
      drain();

      // Positive overflow: 128 x 65536 = 2^23; then a clean packet
      push(24'h7FFFFF, 1'b1, 24'h800000, 1'b1);
      for (int i = 0; i < 128; i++) begin
         send(i == 0, i == 127, AN, AN, 24'd0);
      end
      push(24'd80, 1'b0, 24'd80, 1'b0);
      send(1'b1, 1'b1, A1, B1, 24'd10);
      idle();
      drain();

      // Negative overflow: -2^23 - 8
      push(24'h800000, 1'b1, 24'h7FFFF8, 1'b1);
      send(1'b1, 1'b1, AM1, B2, 24'h800000);
      idle();
      drain();

      // Overflow on beat 1 stays sticky through beat 2
      push(24'h7FFFF7, 1'b1, 24'h80003D, 1'b1);
      send(1'b1, 1'b0, A1, B1, 24'h7FFFFF);
      send(1'b0, 1'b1, AM1, B2, 24'd0);
      idle();
      drain();

      // Backpressure: three packets while out_ready is low
      out_ready = 1'b0;
      push(24'd71, 1'b0, 24'd71, 1'b0);
      push(24'd72, 1'b0, 24'd72, 1'b0);
      push(24'd73, 1'b0, 24'd73, 1'b0);
      send(1'b1, 1'b1, A1, B1, 24'd1);
      send(1'b1, 1'b1, A1, B1, 24'd2);
      send(1'b1, 1'b1, A1, B1, 24'd3);
      idle();
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid_s), 64'd1);
      chk("bp_in_ready", 64'(in_ready_s), 64'd0);
      chk("bp_data", 64'(data_s), 64'd71);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_hold_data", 64'(data_s), 64'd71);
         chk("bp_hold_rdy", 64'(in_ready_s), 64'd0);
      end
      out_ready = 1'b1;
      drain();

      // Reset mid-packet: partial discarded, outputs cleared at once
      send(1'b1, 1'b0, A1, B1, 24'd10);
      send(1'b0, 1'b0, A1, B1, 24'd10);
      idle();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid_s), 64'd0);
      chk("mid_rst_data", 64'(data_s), 64'd0);
      chk("mid_rst_ovf", 64'(ovf_s), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push(24'd80, 1'b0, 24'd80, 1'b0);
      send(1'b0, 1'b1, A1, B1, 24'd10);
      idle();
      drain();
      repeat (5) @(negedge clk);

      chk("result_count_s", 64'(n_res_s), 64'(n_push));
      chk("result_count_w", 64'(n_res_w), 64'(n_push));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
